// File: rtl/one_wire_master_xfer_if.sv
// one_wire_master_xfer_if: command, byte-stream and bus-pin bundle for the 1-Wire master engine
interface one_wire_master_xfer_if #(parameter int LEN_W = 4);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_reset;
  logic [LEN_W-1:0] cmd_wr_len;
  logic [LEN_W-1:0] cmd_rd_len;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             presence;
  logic             busy;
  logic             done;
  logic             err_no_pres;
  logic             ow_pull_low;
  logic             ow_in;
  modport master (
    input  cmd_valid, cmd_reset, cmd_wr_len, cmd_rd_len, tx_data, tx_valid, ow_in,
    output cmd_ready, tx_ready, rx_data, rx_valid, presence, busy, done, err_no_pres, ow_pull_low
  );
  modport slave (
    output cmd_valid, cmd_reset, cmd_wr_len, cmd_rd_len, tx_data, tx_valid, ow_in,
    input  cmd_ready, tx_ready, rx_data, rx_valid, presence, busy, done, err_no_pres, ow_pull_low
  );
endinterface

// File: rtl/one_wire_master_xfer.sv
// one_wire_master_xfer: 1-Wire master running reset/presence, write bytes then read bytes, LSB first
module one_wire_master_xfer #(
  parameter int CLKS_PER_US = 50,
  parameter int LEN_W       = 4,
  parameter int T_RSTL      = 480,
  parameter int T_PDS       = 70,
  parameter int T_RSTH      = 480,
  parameter int T_LOW1      = 6,
  parameter int T_LOW0      = 60,
  parameter int T_RDS       = 15,
  parameter int T_SLOT      = 60,
  parameter int T_REC       = 10
) (
  input logic clk,
  input logic rst,
  one_wire_master_xfer_if.master bus
);
  localparam int T_A   = T_RSTL > T_RSTH ? T_RSTL : T_RSTH;
  localparam int T_B   = T_SLOT > T_REC ? T_SLOT : T_REC;
  localparam int TW    = $clog2((T_A > T_B ? T_A : T_B) * CLKS_PER_US + 1);
  localparam int HOLD1 = (T_SLOT - T_LOW1) * CLKS_PER_US;
  localparam int HOLD0 = (T_SLOT - T_LOW0) * CLKS_PER_US;
  localparam int PDS_T = (T_RSTH - T_PDS) * CLKS_PER_US - 1;
  localparam int RDS_T = (T_SLOT - T_RDS) * CLKS_PER_US - 1;
  typedef enum logic [2:0] {IDLE, RST_LOW, RST_HI, FETCH, WR_LOW, RD_LOW, REC, DONE} state_t;
  state_t           state, state_n;
  logic [TW-1:0]    timer, timer_n;
  logic [1:0]       sync;
  logic [7:0]       sh;
  logic [2:0]       bit_cnt;
  logic [LEN_W-1:0] wr_left, rd_left;
  logic             rst_cmd, accept, tmo, wr_mode, last_bit, ow_s, sample_pres, sample_rd;
  function automatic logic [TW-1:0] ld(input int t);
    return TW'(t * CLKS_PER_US - 1);
  endfunction
  assign bus.cmd_ready   = state == IDLE && !rst;
  assign bus.tx_ready    = state == FETCH && bus.tx_valid;
  assign accept          = bus.cmd_valid && bus.cmd_ready;
  assign tmo             = timer == '0;
  assign wr_mode         = wr_left != '0;
  assign last_bit        = &bit_cnt;
  assign ow_s            = sync[1];
  assign sample_pres     = state == RST_HI && int'(timer) == PDS_T;
  assign sample_rd       = state == RD_LOW && int'(timer) == RDS_T;
  assign bus.ow_pull_low = state == RST_LOW ||
                           (state == WR_LOW && int'(timer) >= (sh[0] ? HOLD1 : HOLD0)) ||
                           (state == RD_LOW && int'(timer) >= HOLD1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = bus.cmd_reset ? RST_LOW : bus.cmd_wr_len != '0 ? FETCH :
                                     bus.cmd_rd_len != '0 ? RD_LOW : DONE;
      RST_LOW: if (tmo) state_n = RST_HI;
      RST_HI:  if (tmo) state_n = !bus.presence ? DONE : wr_mode ? FETCH : rd_left != '0 ? RD_LOW : DONE;
      FETCH:   if (bus.tx_valid) state_n = WR_LOW;
      WR_LOW:  if (tmo) state_n = REC;
      RD_LOW:  if (tmo) state_n = REC;
      REC:     if (tmo) state_n = !last_bit ? (wr_mode ? WR_LOW : RD_LOW) :
                                  wr_mode ? (wr_left != LEN_W'(1) ? FETCH : rd_left != '0 ? RD_LOW : DONE) :
                                  (rd_left != LEN_W'(1) ? RD_LOW : DONE);
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    timer_n = state_n != state ? (state_n == RST_LOW ? ld(T_RSTL) : state_n == RST_HI ? ld(T_RSTH) :
                                  state_n == REC ? ld(T_REC) : state_n inside {WR_LOW, RD_LOW} ? ld(T_SLOT) : '0)
                               : tmo ? '0 : timer - TW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      timer           <= '0;
      sync            <= 2'b11;
      sh              <= '0;
      bit_cnt         <= '0;
      wr_left         <= '0;
      rd_left         <= '0;
      rst_cmd         <= 1'b0;
      bus.presence    <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.err_no_pres <= 1'b0;
      bus.rx_valid    <= 1'b0;
      bus.rx_data     <= '0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      sync         <= {sync[0], bus.ow_in};
      bus.done     <= state == DONE;
      bus.rx_valid <= 1'b0;
      if (accept) begin
        wr_left         <= bus.cmd_wr_len;
        rd_left         <= bus.cmd_rd_len;
        rst_cmd         <= bus.cmd_reset;
        bit_cnt         <= '0;
        bus.busy        <= 1'b1;
        bus.err_no_pres <= 1'b0;
      end else if (bus.done) bus.busy <= 1'b0;
      if (state == DONE) bus.err_no_pres <= rst_cmd & ~bus.presence;
      if (sample_pres) bus.presence <= ~ow_s;
      if (bus.tx_ready) sh <= bus.tx_data;
      if (sample_rd) sh <= {ow_s, sh[7:1]};
      if (state == REC && tmo) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (wr_mode) begin
          sh <= sh >> 1;
          if (last_bit) wr_left <= wr_left - LEN_W'(1);
        end else if (last_bit) begin
          rd_left      <= rd_left - LEN_W'(1);
          bus.rx_data  <= sh;
          bus.rx_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_one_wire_master_xfer.sv
// tb_one_wire_master_xfer: random and directed 1-Wire transactions against a slot-level reference model
module tb_one_wire_master_xfer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic slave_pull = 1'b0;
  always #5 clk = ~clk;
  one_wire_master_xfer_if #(.LEN_W(4)) bus ();
  one_wire_master_xfer #(.CLKS_PER_US(1), .LEN_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.ow_in = ~(bus.ow_pull_low | slave_pull);
  int nvec = 0, nerr = 0;
  task automatic check(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  int cyc = 0, lstart = 0, ndone = 0, nslot = 0, sl_wr_slots = 0;
  int pres_from = 0, pres_to = 0, drive_to = 0;
  bit prev = 0, rst_first = 0, sl_present = 0, b;
  int lows[$];
  logic [7:0] rxq[$];
  bit rdbits[$];
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (bus.ow_pull_low && !prev) begin
      lstart = cyc;
      if (rst_first) rst_first = 0;
      else begin
        if (nslot >= sl_wr_slots && rdbits.size() != 0) begin
          b = rdbits.pop_front();
          if (!b) drive_to = cyc + 20;
        end
        nslot++;
      end
    end
    if (!bus.ow_pull_low && prev) begin
      lows.push_back(cyc - lstart);
      if (cyc - lstart > 300 && sl_present) begin
        pres_from = cyc + 20;
        pres_to   = cyc + 180;
      end
    end
    if (bus.rx_valid) rxq.push_back(bus.rx_data);
    if (bus.done) ndone++;
    slave_pull = (cyc >= pres_from && cyc < pres_to) || cyc < drive_to;
    prev = bus.ow_pull_low;
  end
  logic [7:0] txq[$];
  int gapq[$];
  bit take = 0, flush = 0;
  int ntx = 0;
  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    forever begin
      @(negedge clk);
      if (flush) begin
        txq.delete();
        gapq.delete();
        bus.tx_valid = 1'b0;
        take = 0;
        flush = 0;
      end
      if (take) begin
        void'(txq.pop_front());
        void'(gapq.pop_front());
        bus.tx_valid = 1'b0;
        take = 0;
        ntx++;
      end
      if (!bus.tx_valid && txq.size() != 0) begin
        if (gapq[0] > 0) gapq[0] = gapq[0] - 1;
        else begin
          bus.tx_valid = 1'b1;
          bus.tx_data  = txq[0];
        end
      end
      #1 take = bus.tx_valid && bus.tx_ready;
    end
  end
  task automatic setup(input bit r, input bit pres, input int nwr, input int nrd,
                       input logic [7:0] wb[2], input logic [7:0] rb[2], input int gap);
    lows.delete();
    rxq.delete();
    rdbits.delete();
    ndone = 0;
    ntx = 0;
    nslot = 0;
    rst_first = r;
    sl_present = pres;
    sl_wr_slots = 8 * nwr;
    for (int i = 0; i < nrd; i++) for (int k = 0; k < 8; k++) rdbits.push_back(rb[i][k]);
    for (int i = 0; i < nwr; i++) begin
      txq.push_back(wb[i]);
      gapq.push_back(i == 1 ? gap : 0);
    end
    @(negedge clk);
    check("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_reset  = r;
    bus.cmd_wr_len = 4'(nwr);
    bus.cmd_rd_len = 4'(nrd);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("busy_on_accept", bus.busy, 1);
  endtask
  task automatic run_cmd(input bit r, input bit pres, input int nwr, input int nrd, input int gap,
                         input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] r0, input logic [7:0] r1);
    logic [7:0] wb[2], rb[2];
    int exp_lows[$];
    logic [7:0] exp_rx[$];
    bit go, got_done;
    int n;
    wb = '{w0, w1};
    rb = '{r0, r1};
    go = !r || pres;
    if (r) exp_lows.push_back(480);
    if (go) begin
      for (int i = 0; i < nwr; i++) for (int k = 0; k < 8; k++) exp_lows.push_back(wb[i][k] ? 6 : 60);
      for (int i = 0; i < nrd; i++) begin
        for (int k = 0; k < 8; k++) exp_lows.push_back(6);
        exp_rx.push_back(rb[i]);
      end
    end
    setup(r, pres, nwr, nrd, wb, rb, gap);
    n = 1;
    got_done = 0;
    while (n < 30000 && !got_done) begin
      if (bus.done) got_done = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check("done_seen", got_done, 1);
    if (!r && nwr == 0 && nrd == 0) check("done_latency", n, 2);
    @(negedge clk);
    check("busy_after_done", bus.busy, 0);
    check("done_one_cycle", bus.done, 0);
    flush = 1;
    repeat (3) @(negedge clk);
    check("n_done", ndone, 1);
    check("n_lows", lows.size(), exp_lows.size());
    for (int i = 0; i < exp_lows.size() && i < lows.size(); i++)
      check($sformatf("low_width[%0d]", i), lows[i], exp_lows[i]);
    check("n_tx", ntx, go ? nwr : 0);
    check("n_rx", rxq.size(), exp_rx.size());
    for (int i = 0; i < exp_rx.size() && i < rxq.size(); i++)
      check($sformatf("rx_data[%0d]", i), rxq[i], exp_rx[i]);
    if (r) check("presence", bus.presence, pres);
    check("err_no_pres", bus.err_no_pres, r && !pres);
  endtask
  task automatic reset_mid();
    logic [7:0] wb[2], rb[2];
    int n;
    wb = '{8'h00, 8'h00};
    rb = '{8'h00, 8'h00};
    setup(0, 0, 1, 1, wb, rb, 0);
    n = 0;
    while (n < 2000 && !bus.ow_pull_low) begin
      @(negedge clk);
      n++;
    end
    check("wr_slot_started", bus.ow_pull_low, 1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("pull_after_rst", bus.ow_pull_low, 0);
    check("busy_after_rst", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    flush = 1;
    repeat (300) @(negedge clk);
    check("no_done_after_rst", ndone, 0);
    check("no_rx_after_rst", rxq.size(), 0);
    check("lows_after_rst", lows.size(), 1);
    check("ready_after_rst", bus.cmd_ready, 1);
  endtask
  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_reset  = 1'b0;
    bus.cmd_wr_len = '0;
    bus.cmd_rd_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pull", bus.ow_pull_low, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_presence", bus.presence, 0);
    check("rst_err", bus.err_no_pres, 0);
    check("rst_tx_ready", bus.tx_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    run_cmd(1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    run_cmd(1, 0, 1, 0, 0, 8'h5A, 8'h00, 8'h00, 8'h00);
    run_cmd(0, 0, 2, 0, 0, 8'hA5, 8'h3C, 8'h00, 8'h00);
    run_cmd(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h96, 8'h00);
    run_cmd(0, 0, 2, 1, 760, 8'($urandom), 8'($urandom), 8'($urandom), 8'h00);
    run_cmd(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    run_cmd(1, 1, 1, 1, 0, 8'($urandom), 8'h00, 8'($urandom), 8'h00);
    for (int i = 0; i < 6; i++)
      run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 800)),
              8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    reset_mid();
    run_cmd(0, 0, 1, 1, 0, 8'($urandom), 8'h00, 8'($urandom), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
